// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: states, opcodes, select codes.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL2_W   = 2;
  localparam int unsigned M2R_W    = 3;

  typedef enum logic [4:0] {
    S_RESET,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_JR,
    S_ADDR,
    S_LW0,
    S_LW1,
    S_LW2,
    S_LW3,
    S_SW0,
    S_BR,
    S_JMP,
    S_JAL0,
    S_JAL1,
    S_EXC0,
    S_EXC1
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;

  // ALU operations
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;

  // ALU B-input select
  localparam logic [SEL2_W-1:0] SRCB_B      = 2'd0;
  localparam logic [SEL2_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SEL2_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SEL2_W-1:0] SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [SEL2_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL2_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL2_W-1:0] PCSRC_JUMP   = 2'd2;

  // Destination register select
  localparam logic [SEL2_W-1:0] REGDST_RT = 2'd0;
  localparam logic [SEL2_W-1:0] REGDST_RD = 2'd1;
  localparam logic [SEL2_W-1:0] REGDST_RA = 2'd2;
  localparam logic [SEL2_W-1:0] REGDST_SP = 2'd3;

  // Register write-data select
  localparam logic [M2R_W-1:0] M2R_MDR    = 3'd0;
  localparam logic [M2R_W-1:0] M2R_ALUOUT = 3'd1;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic r_alu;
    logic jr;
    logic addi;
    logic lw;
    logic sw;
    logic br;
    logic j;
    logic jal;
    logic invalid;
  } instr_class_t;

  // ALU operation for the supported R-type arithmetic functions
  function automatic logic [ALU_OP_W-1:0] funct_alu_op(input logic [FUNCT_W-1:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct classifier feeding the DECODE transition.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output instr_class_t        cls
);

  // Exactly one class bit set; anything unrecognised is invalid
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND: cls.r_alu   = 1'b1;
          FN_JR:                  cls.jr      = 1'b1;
          default:                cls.invalid = 1'b1;
        endcase
      end
      OP_ADDI:        cls.addi    = 1'b1;
      OP_LW:          cls.lw      = 1'b1;
      OP_SW:          cls.sw      = 1'b1;
      OP_BEQ, OP_BNE: cls.br      = 1'b1;
      OP_J:           cls.j       = 1'b1;
      OP_JAL:         cls.jal     = 1'b1;
      default:        cls.invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS-subset main controller: one state per clock, Moore outputs,
// overflow / invalid-instruction exceptions and post-reset $29 initialisation.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter logic [M2R_W-1:0]  SP_INIT_SEL = 3'd5,
  parameter logic [SEL2_W-1:0] EXC_VEC_SEL = 2'd3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                overflow,
  input  logic                zero,
  output logic                pc_write,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                aluout_write,
  output logic                ab_write,
  output logic                mdr_write,
  output logic                epc_write,
  output logic                iord,
  output logic                alu_src_a,
  output logic [SEL2_W-1:0]   alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [SEL2_W-1:0]   pc_source,
  output logic [SEL2_W-1:0]   reg_dst,
  output logic [M2R_W-1:0]    mem_to_reg,
  output logic                exc_cause,
  output logic                reset_out
);

  state_t       state;
  state_t       next_state;
  instr_class_t cls;
  logic         is_addsub;

  instr_class_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // Only add/sub trap on overflow; and never does
  assign is_addsub = (funct == FN_ADD) || (funct == FN_SUB);

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) state <= S_RESET;
    else       state <= next_state;
  end

  // Exception cause captured on entry to EXC0: 1 when coming from an EXEC overflow
  always_ff @(posedge clock) begin
    if (reset)                     exc_cause <= 1'b0;
    else if (next_state == S_EXC0) exc_cause <= (state == S_EXEC_R) || (state == S_EXEC_I);
  end

  // Next-state and state-decoded outputs
  always_comb begin
    next_state   = state;
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    aluout_write = 1'b0;
    ab_write     = 1'b0;
    mdr_write    = 1'b0;
    epc_write    = 1'b0;
    iord         = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_PASS;
    pc_source    = PCSRC_ALU;
    reg_dst      = REGDST_RT;
    mem_to_reg   = M2R_MDR;
    reset_out    = 1'b0;

    case (state)
      S_RESET: begin
        reset_out  = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = REGDST_SP;
        mem_to_reg = SP_INIT_SEL;
        next_state = S_FETCH0;
      end
      S_FETCH0, S_FETCH1, S_FETCH2: begin
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (state == S_FETCH0) begin
          next_state = S_FETCH1;
        end else if (state == S_FETCH1) begin
          next_state = S_FETCH2;
        end else begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_source  = PCSRC_ALU;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_write     = 1'b1;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_IMM_SH;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        if      (cls.r_alu)         next_state = S_EXEC_R;
        else if (cls.jr)            next_state = S_JR;
        else if (cls.addi)          next_state = S_EXEC_I;
        else if (cls.lw || cls.sw)  next_state = S_ADDR;
        else if (cls.br)            next_state = S_BR;
        else if (cls.j)             next_state = S_JMP;
        else if (cls.jal)           next_state = S_JAL0;
        else                        next_state = S_EXC0;
      end
      S_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_B;
        alu_op       = funct_alu_op(funct);
        aluout_write = 1'b1;
        next_state   = (is_addsub && overflow) ? S_EXC0 : S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RD;
        mem_to_reg = M2R_ALUOUT;
        next_state = S_FETCH0;
      end
      S_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        next_state   = overflow ? S_EXC0 : S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        next_state = S_FETCH0;
      end
      S_JR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_PASS;
        pc_source  = PCSRC_ALU;
        pc_write   = 1'b1;
        next_state = S_FETCH0;
      end
      S_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        next_state   = (opcode == OP_LW) ? S_LW0 : S_SW0;
      end
      S_LW0: begin
        iord       = 1'b1;
        next_state = S_LW1;
      end
      S_LW1: begin
        iord       = 1'b1;
        next_state = S_LW2;
      end
      S_LW2: begin
        iord       = 1'b1;
        mdr_write  = 1'b1;
        next_state = S_LW3;
      end
      S_LW3: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_MDR;
        next_state = S_FETCH0;
      end
      S_SW0: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        next_state = S_FETCH0;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        next_state = S_FETCH0;
      end
      S_JMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH0;
      end
      S_JAL0: begin
        alu_src_a    = 1'b0;
        alu_op       = ALU_PASS;
        aluout_write = 1'b1;
        next_state   = S_JAL1;
      end
      S_JAL1: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = M2R_ALUOUT;
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH0;
      end
      S_EXC0: begin
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_SUB;
        epc_write  = 1'b1;
        next_state = S_EXC1;
      end
      S_EXC1: begin
        pc_source  = EXC_VEC_SEL;
        pc_write   = 1'b1;
        next_state = S_FETCH0;
      end
      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomised self-checking bench for main_control_fsm against a per-instruction
// step-table model of the control sequence.
module tb_main_control_fsm;

  // Output bundle in a fixed field order for whole-vector comparison
  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       aluout_write;
    logic       ab_write;
    logic       mdr_write;
    logic       epc_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic       reset_out;
  } out_t;

  // Step codes of the expected sequence
  localparam int ST_RST = 0,  ST_F0 = 1,   ST_F1 = 2,   ST_F2 = 3,   ST_DEC = 4;
  localparam int ST_EXR = 5,  ST_WBR = 6,  ST_EXI = 7,  ST_WBI = 8,  ST_JR = 9;
  localparam int ST_ADR = 10, ST_LW0 = 11, ST_LW1 = 12, ST_LW2 = 13, ST_LW3 = 14;
  localparam int ST_SW0 = 15, ST_BR = 16,  ST_JMP = 17, ST_JL0 = 18, ST_JL1 = 19;
  localparam int ST_EX0 = 20, ST_EX1 = 21;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       zero;
  logic       pc_write, mem_write, ir_write, reg_write, aluout_write, ab_write;
  logic       mdr_write, epc_write, iord, alu_src_a, exc_cause, reset_out;
  logic [1:0] alu_src_b, pc_source, reg_dst;
  logic [2:0] alu_op, mem_to_reg;
  out_t       obs;

  int   checks   = 0;
  int   failures = 0;
  logic exp_cause = 1'b0;
  int   instr_no  = 0;

  always #5 clock = ~clock;

  main_control_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .overflow     (overflow),
    .zero         (zero),
    .pc_write     (pc_write),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .aluout_write (aluout_write),
    .ab_write     (ab_write),
    .mdr_write    (mdr_write),
    .epc_write    (epc_write),
    .iord         (iord),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .exc_cause    (exc_cause),
    .reset_out    (reset_out)
  );

  assign obs = {pc_write, mem_write, ir_write, reg_write, aluout_write, ab_write,
                mdr_write, epc_write, iord, alu_src_a, alu_src_b, alu_op,
                pc_source, reg_dst, mem_to_reg, reset_out};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected control outputs for one step of an instruction
  function automatic out_t exp_out(input int st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic zv);
    out_t o;
    o = '0;
    case (st)
      ST_RST: begin o.reset_out = 1; o.reg_write = 1; o.reg_dst = 3; o.mem_to_reg = 5; end
      ST_F0, ST_F1: begin o.alu_src_b = 1; o.alu_op = 1; end
      ST_F2: begin o.alu_src_b = 1; o.alu_op = 1; o.ir_write = 1; o.pc_write = 1; end
      ST_DEC: begin o.ab_write = 1; o.alu_src_b = 3; o.alu_op = 1; o.aluout_write = 1; end
      ST_EXR: begin
        o.alu_src_a = 1; o.aluout_write = 1;
        o.alu_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
      end
      ST_WBR: begin o.reg_write = 1; o.reg_dst = 1; o.mem_to_reg = 1; end
      ST_EXI, ST_ADR: begin o.alu_src_a = 1; o.alu_src_b = 2; o.alu_op = 1; o.aluout_write = 1; end
      ST_WBI: begin o.reg_write = 1; o.mem_to_reg = 1; end
      ST_JR:  begin o.alu_src_a = 1; o.pc_write = 1; end
      ST_LW0, ST_LW1: o.iord = 1;
      ST_LW2: begin o.iord = 1; o.mdr_write = 1; end
      ST_LW3: o.reg_write = 1;
      ST_SW0: begin o.iord = 1; o.mem_write = 1; end
      ST_BR: begin
        o.alu_src_a = 1; o.alu_op = 2; o.pc_source = 1;
        o.pc_write = ((op == 6'h04) && zv) || ((op == 6'h05) && !zv);
      end
      ST_JMP: begin o.pc_source = 2; o.pc_write = 1; end
      ST_JL0: o.aluout_write = 1;
      ST_JL1: begin
        o.reg_write = 1; o.reg_dst = 2; o.mem_to_reg = 1; o.pc_source = 2; o.pc_write = 1;
      end
      ST_EX0: begin o.alu_src_b = 1; o.alu_op = 2; o.epc_write = 1; end
      ST_EX1: begin o.pc_source = 3; o.pc_write = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Hold reset high for n cycles, then one released cycle still in RESET
  task automatic reset_cycles(input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clock);
      reset    = (k < n);
      overflow = 1'($urandom_range(0, 1));
      zero     = 1'($urandom_range(0, 1));
      exp_cause = 1'b0;
      #1;
      check_eq($sformatf("rst%0d.out", k), 32'(obs), 32'(exp_out(ST_RST, 6'h0, 6'h0, 1'b0)));
      check_eq($sformatf("rst%0d.exc_cause", k), 32'(exc_cause), 32'(exp_cause));
    end
  endtask

  // Run one instruction from FETCH0; abort_at >= 0 raises reset in that cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int ovf_force, input int zero_force, input int abort_at);
    logic ovf_bits [9];
    logic zero_bits [9];
    int   seq [$];
    bit   ovf;
    bit   aborted;
    for (int i = 0; i < 9; i++) begin
      ovf_bits[i]  = 1'($urandom_range(0, 1));
      zero_bits[i] = 1'($urandom_range(0, 1));
    end
    if (ovf_force >= 0)  ovf_bits[4]  = 1'(ovf_force);
    if (zero_force >= 0) zero_bits[4] = 1'(zero_force);
    ovf = ovf_bits[4];
    seq = '{ST_F0, ST_F1, ST_F2, ST_DEC};
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
      seq.push_back(ST_EXR);
      if (ovf) begin seq.push_back(ST_EX0); seq.push_back(ST_EX1); end
      else seq.push_back(ST_WBR);
    end else if (op == 6'h00 && fn == 6'h24) begin
      seq.push_back(ST_EXR); seq.push_back(ST_WBR);
    end else if (op == 6'h00 && fn == 6'h08) seq.push_back(ST_JR);
    else if (op == 6'h08) begin
      seq.push_back(ST_EXI);
      if (ovf) begin seq.push_back(ST_EX0); seq.push_back(ST_EX1); end
      else seq.push_back(ST_WBI);
    end else if (op == 6'h23) seq = {seq, ST_ADR, ST_LW0, ST_LW1, ST_LW2, ST_LW3};
    else if (op == 6'h2B) seq = {seq, ST_ADR, ST_SW0};
    else if (op == 6'h04 || op == 6'h05) seq.push_back(ST_BR);
    else if (op == 6'h02) seq.push_back(ST_JMP);
    else if (op == 6'h03) begin seq.push_back(ST_JL0); seq.push_back(ST_JL1); end
    else begin seq.push_back(ST_EX0); seq.push_back(ST_EX1); end

    aborted = 0;
    for (int c = 0; c < seq.size() && !aborted; c++) begin
      @(negedge clock);
      opcode   = op;
      funct    = fn;
      overflow = ovf_bits[c];
      zero     = zero_bits[c];
      reset    = (c == abort_at);
      if (seq[c] == ST_EX0) exp_cause = (seq[c-1] == ST_EXR || seq[c-1] == ST_EXI);
      #1;
      check_eq($sformatf("i%0d.c%0d.st%0d.op%0h.out", instr_no, c, seq[c], op),
               32'(obs), 32'(exp_out(seq[c], op, fn, zero_bits[c])));
      check_eq($sformatf("i%0d.c%0d.exc_cause", instr_no, c), 32'(exc_cause), 32'(exp_cause));
      if (c == abort_at) aborted = 1;
    end
    if (aborted) reset_cycles(1);
    instr_no++;
  endtask

  // Random instruction encoding, including invalid opcodes and functs
  task automatic pick_instr(output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = $urandom_range(0, 12);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0: begin op = 6'h00; fn = 6'h20; end
      1: begin op = 6'h00; fn = 6'h22; end
      2: begin op = 6'h00; fn = 6'h24; end
      3: begin op = 6'h00; fn = 6'h08; end
      4: begin
        op = 6'h00;
        while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h08)
          fn = 6'($urandom_range(0, 63));
      end
      5:  op = 6'h08;
      6:  op = 6'h23;
      7:  op = 6'h2B;
      8:  op = 6'h04;
      9:  op = 6'h05;
      10: op = 6'h02;
      11: op = 6'h03;
      default: begin
        op = 6'($urandom_range(1, 63));
        while (op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
               op == 6'h08 || op == 6'h23 || op == 6'h2B)
          op = 6'($urandom_range(1, 63));
      end
    endcase
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         ab;
    reset    = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h00;
    overflow = 1'b0;
    zero     = 1'b0;
    @(posedge clock);
    reset_cycles(3);

    run_instr(6'h00, 6'h20, 0, -1, -1);   // add, no overflow
    run_instr(6'h00, 6'h20, 1, -1, -1);   // add, overflow -> cause 1
    run_instr(6'h23, 6'h00, -1, -1, -1);  // lw
    run_instr(6'h04, 6'h00, -1, 1, -1);   // beq taken
    run_instr(6'h05, 6'h00, -1, 1, -1);   // bne not taken
    run_instr(6'h03, 6'h00, -1, -1, -1);  // jal
    run_instr(6'h3F, 6'h00, -1, -1, -1);  // invalid opcode -> cause 0
    run_instr(6'h08, 6'h00, 1, -1, -1);   // addi overflow -> cause 1
    run_instr(6'h23, 6'h00, -1, -1, 6);   // lw aborted by reset in LW1

    for (int n = 0; n < 250; n++) begin
      pick_instr(op, fn);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(op, fn, -1, -1, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main controller for the MIPS-subset CPU datapath. It decodes `opcode`/`funct` from the instruction register and sequences PC, memory, IR, register bank, ALU input muxes and ALU operation one state per clock. It also handles overflow and invalid-instruction exceptions, and the post-reset stack-pointer initialisation. It is instantiated in `cpu` alongside `ula_control`, and it replaces the bare write-enable vector.

## Interface
Parameters:
- `SP_INIT_SEL`, default 3'd5: `mem_to_reg` code selecting constant 227 for the $29 init.
- `EXC_VEC_SEL`, default 2'd3: `pc_source` code selecting the exception vector.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `overflow` in 1: ula32 overflow flag, combinational, from the current A/B.
- `zero` in 1: ula32 zero flag.
- `pc_write`, `mem_write`, `ir_write`, `reg_write`, `aluout_write`, `ab_write`, `mdr_write`, `epc_write` out 1 each: register/memory write enables.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- `alu_op` out 3: 000 pass A, 001 add, 010 sub, 011 and.
- `pc_source` out 2: 0 = ALU result S, 1 = ALUOut, 2 = jump target {PC[31:28],IR[25:0],00}, 3 = exception vector.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = $31, 3 = $29.
- `mem_to_reg` out 3: 0 = MDR, 1 = ALUOut, 5 = const 227.
- `exc_cause` out 1: 0 = invalid instruction, 1 = overflow. Registered; updated only in EXC0.
- `reset_out` out 1: high while in RESET.

## Operation
Supported instructions:
- R-type (opcode 0): add 0x20, sub 0x22, and 0x24, jr 0x08.
- I/J-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- Any other opcode, or unknown funct with opcode 0, is an invalid instruction and goes to EXC0.

Defaults and decoding:
- Every output defaults to 0 in every state; each state asserts only what is listed below.
- Outputs are Moore (state-decoded), except `pc_write` in BR and the WB/EXC choice in EXEC.

States:
- RESET: `reset_out`=1, `reg_write`=1, `reg_dst`=3, `mem_to_reg`=SP_INIT_SEL. Next: FETCH0.
- FETCH0: `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add. Next: FETCH1.
- FETCH1: same as FETCH0 (memory wait). Next: FETCH2.
- FETCH2: FETCH0 outputs plus `ir_write`=1, `pc_write`=1, `pc_source`=0. Next: DECODE.
- DECODE: `ab_write`=1, `alu_src_a`=0, `alu_src_b`=3, `alu_op`=add, `aluout_write`=1 (branch target). Next by class.
- EXEC_R (add/sub/and):
  - Outputs: `alu_src_a`=1, `alu_src_b`=0, `alu_op` from funct, `aluout_write`=1.
  - Next: EXC0 if add/sub and `overflow`, else WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=1.
- EXEC_I (addi):
  - Outputs: `alu_src_a`=1, `alu_src_b`=2, add, `aluout_write`=1.
  - Next: EXC0 on `overflow`, else WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
- JR: `alu_src_a`=1, `alu_op`=pass, `pc_source`=0, `pc_write`=1.
- ADDR (lw/sw): `alu_src_a`=1, `alu_src_b`=2, add, `aluout_write`=1. Next: LW0 or SW0.
- lw path:
  - LW0, LW1: `iord`=1.
  - LW2: `iord`=1, `mdr_write`=1.
  - LW3: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
- SW0: `iord`=1, `mem_write`=1.
- BR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=0, sub, `pc_source`=1.
  - `pc_write` = (beq & `zero`) | (bne & ~`zero`).
- JMP: `pc_source`=2, `pc_write`=1.
- JAL0: `alu_src_a`=0, pass, `aluout_write`=1.
- JAL1: `reg_write`=1, `reg_dst`=2, `mem_to_reg`=1, `pc_source`=2, `pc_write`=1.
- EXC0: `alu_src_a`=0, `alu_src_b`=1, sub, `epc_write`=1 (EPC ← PC−4); latch `exc_cause`.
- EXC1: `pc_source`=EXC_VEC_SEL, `pc_write`=1.
- Every terminal state (WB_R, WB_I, JR, LW3, SW0, BR, JMP, JAL1, EXC1) returns to FETCH0.

## Timing
- Reset:
  - `reset` sampled high: next state RESET, `exc_cause` cleared to 0.
  - While `reset` is high, the FSM stays in RESET; the $29 write repeats harmlessly.
  - Reset asserted mid-instruction aborts it at the next edge; no partial write occurs after that edge.
- Reset values: state=RESET; `reset_out`=1, `reg_write`=1, `reg_dst`=3, `mem_to_reg`=5; all other outputs 0.
- Memory: data is valid two cycles after the address is presented, so the address is held for two cycles before `ir_write`/`mdr_write`.
- Cycles per instruction, FETCH0 to next FETCH0:
  - 5: beq/bne, j, jr.
  - 6: R-type, addi, sw, jal.
  - 9: lw.
  - Exception: 7 (5 + EXC0 + EXC1) for overflow; 6 for invalid instruction (DECODE → EXC0).
- Overflow during EXEC: `reg_write` is never asserted for that instruction.

## Structure
- Package `ctrl_pkg` holds:
  - state enum;
  - opcode and funct constants;
  - `alu_op` codes;
  - `alu_src_b`, `pc_source`, `reg_dst`, `mem_to_reg` select codes.
- One combinational sub-module, `instr_class_decode` (`opcode`, `funct` → one-hot class {R_ALU, JR, ADDI, LW, SW, BR, J, JAL, INVALID}), feeds the DECODE transition.

## Test plan
- Release reset after 3 cycles → RESET for one cycle with `reg_write`=1, `reg_dst`=3, `mem_to_reg`=5, then FETCH0; `ir_write` high exactly in cycle 3 after release.
- add (opcode 0, funct 0x20), `overflow`=0 → 6-cycle sequence; WB_R has `reg_write`=1, `reg_dst`=1. Repeat with `overflow`=1 in EXEC_R → EXC0 with `epc_write`=1, `exc_cause`=1, then EXC1 with `pc_source`=3; no `reg_write`.
- lw (0x23) → 9 cycles; `iord`=1 in LW0–LW2; `mdr_write` only in LW2; LW3 `mem_to_reg`=0, `reg_dst`=0.
- beq with `zero`=1 → `pc_write`=1 in BR. bne with `zero`=1 → `pc_write`=0. Both return to FETCH0 in 5 cycles.
- jal (0x03) → JAL1 asserts `reg_dst`=2, `pc_source`=2, `pc_write`=1. Opcode 0x3F → EXC0 with `exc_cause`=0.
- Assert `reset` during LW1 → next state RESET; `mdr_write` and `reg_write` for the aborted lw never asserted.
